// File: rtl/dp_port_arbiter.sv
// dp_port_arbiter: round-robin owner of the BCU data-pointer port,
// with one-step cooldown after each completion and locked sequences.
package dp_port_arbiter_pkg;
  typedef enum logic [1:0] {
    DS0 = 2'd0,
    DS1 = 2'd1,
    PS  = 2'd2,
    SS  = 2'd3
  } sreg_index_e;
endpackage

module dp_port_arbiter
  import dp_port_arbiter_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce_1,
  input  logic                     ce_2,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_lock,
  input  logic [N_REQ-1:0][15:0]   req_addr,
  input  logic [N_REQ-1:0][15:0]   req_dout,
  input  sreg_index_e [N_REQ-1:0]  req_sreg,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ-1:0]         req_wide,
  input  logic [N_REQ-1:0]         req_io,
  input  logic [N_REQ-1:0]         req_zero_seg,
  output logic [N_REQ-1:0]         ack,
  output logic [15:0]              req_din,
  output logic [15:0]              dp_addr,
  output logic [15:0]              dp_dout,
  output sreg_index_e              dp_sreg,
  output logic                     dp_write,
  output logic                     dp_wide,
  output logic                     dp_io,
  output logic                     dp_zero_seg,
  output logic                     dp_req,
  input  logic                     dp_ready,
  input  logic [15:0]              dp_din,
  output logic                     buslock_prefix,
  output logic [1:0]               grant_id,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             step;
  logic             found;
  logic             grant_go;
  logic             done;
  logic             own_lock;
  logic             lock_active;
  logic             cur_lock;
  logic [1:0]       lock_owner;
  logic [1:0]       win;
  logic [2:0]       sum;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] grant_oh;

  assign step = ce_1 | ce_2;

  always_comb begin
    owner_oh = '0;
    grant_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      owner_oh[i] = (lock_owner == 2'(i));
      grant_oh[i] = (grant_id == 2'(i));
    end
  end

  assign own_lock = |(req_lock & owner_oh);

  // Scan upward from the last winner, wrapping at N_REQ.
  always_comb begin
    elig = req_valid & ~mask;
    if (lock_active) elig = elig & owner_oh;
    found = 1'b0;
    win   = grant_id;
    sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, grant_id} + 3'(k);
      if (sum >= 3'(N_REQ)) sum = sum - 3'(N_REQ);
      if (!found && elig[sum[1:0]]) begin
        found = 1'b1;
        win   = sum[1:0];
      end
    end
  end

  assign grant_go = step && (state_q == IDLE) && found && dp_ready;
  assign done     = step && (state_q == WAIT) && dp_ready;

  always_comb begin
    state_d = state_q;
    if (step) begin
      unique case (state_q)
        IDLE:    if (found && dp_ready) state_d = ISSUE;
        ISSUE:   state_d = WAIT;
        WAIT:    if (dp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ack         <= '0;
      req_din     <= '0;
      dp_addr     <= '0;
      dp_dout     <= '0;
      dp_sreg     <= DS0;
      dp_write    <= 1'b0;
      dp_wide     <= 1'b0;
      dp_io       <= 1'b0;
      dp_zero_seg <= 1'b0;
      grant_id    <= 2'(N_REQ - 1);
      lock_active <= 1'b0;
      lock_owner  <= '0;
      cur_lock    <= 1'b0;
      mask        <= '0;
    end else begin
      state_q <= state_d;
      ack     <= '0;
      if (step && state_q == IDLE) begin
        mask <= '0;
        if (lock_active && !own_lock) lock_active <= 1'b0;
      end
      if (grant_go) begin
        dp_addr     <= req_addr[win];
        dp_dout     <= req_dout[win];
        dp_sreg     <= req_sreg[win];
        dp_write    <= req_write[win];
        dp_wide     <= req_wide[win];
        dp_io       <= req_io[win];
        dp_zero_seg <= req_zero_seg[win];
        cur_lock    <= req_lock[win];
        grant_id    <= win;
      end
      if (done) begin
        req_din <= dp_din;
        ack     <= grant_oh;
        mask    <= grant_oh;
        if (|(req_lock & grant_oh)) begin
          lock_active <= 1'b1;
          lock_owner  <= grant_id;
        end else if (lock_active && lock_owner == grant_id) begin
          lock_active <= 1'b0;
        end
      end
    end
  end

  assign busy           = (state_q != IDLE);
  assign dp_req         = (state_q == ISSUE);
  assign buslock_prefix = lock_active | (busy & cur_lock);

endmodule

// File: tb/tb_dp_port_arbiter.sv
// tb_dp_port_arbiter: directed scenarios plus a transaction-level
// round-robin model compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_dp_port_arbiter;
  import dp_port_arbiter_pkg::*;

  localparam int N = 3;

  logic clk = 0;
  logic reset = 1;
  logic ce_1 = 1;
  logic ce_2 = 0;
  logic ce_tog = 0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_lock = '0;
  logic [N-1:0] req_write = '0;
  logic [N-1:0] req_wide = '0;
  logic [N-1:0] req_io = '0;
  logic [N-1:0] req_zero_seg = '0;
  logic [N-1:0][15:0] req_addr;
  logic [N-1:0][15:0] req_dout;
  sreg_index_e [N-1:0] req_sreg;

  logic [N-1:0] ack;
  logic [15:0]  req_din, dp_addr, dp_dout;
  sreg_index_e  dp_sreg;
  logic dp_write, dp_wide, dp_io, dp_zero_seg, dp_req;
  logic buslock_prefix, busy;
  logic [1:0] grant_id;

  logic bcu_ready = 1;
  logic hold_lo = 0;
  logic dp_ready;
  logic [15:0] dp_din = '0;
  logic [15:0] bcu_data = 16'h0100;
  int bcu_lat = 2;

  assign dp_ready = bcu_ready & ~hold_lo;

  int total = 0;
  int bad = 0;
  int nreq = 0;
  int acks[$];

  dp_port_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .reset(reset), .ce_1(ce_1), .ce_2(ce_2),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_dout(req_dout), .req_sreg(req_sreg),
    .req_write(req_write), .req_wide(req_wide), .req_io(req_io),
    .req_zero_seg(req_zero_seg), .ack(ack), .req_din(req_din),
    .dp_addr(dp_addr), .dp_dout(dp_dout), .dp_sreg(dp_sreg),
    .dp_write(dp_write), .dp_wide(dp_wide), .dp_io(dp_io),
    .dp_zero_seg(dp_zero_seg), .dp_req(dp_req), .dp_ready(dp_ready),
    .dp_din(dp_din), .buslock_prefix(buslock_prefix),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: who may win, from the plain round-robin rule.
  function automatic int rr_pick(input logic [N-1:0] v, input int last,
                                 input int cool, input int owner);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c[1:0]] && c != cool && (owner < 0 || c == owner))
        return c;
    end
    return -1;
  endfunction

  bit m_valid = 0;
  bit m_issue, m_out, m_txlock;
  int m_last, m_cool, m_owner;
  logic [N-1:0] m_ack;
  logic [15:0] m_din, m_addr, m_dout;
  sreg_index_e m_sreg;
  logic [3:0] m_attr;

  always @(posedge clk) begin : model
    int p;
    if (reset) begin
      m_valid = 1; m_issue = 0; m_out = 0; m_txlock = 0;
      m_last = N - 1; m_cool = -1; m_owner = -1;
      m_ack = '0; m_din = '0; m_addr = '0; m_dout = '0;
      m_sreg = DS0; m_attr = '0;
    end else begin
      m_ack = '0;
      if (ce_1 | ce_2) begin
        if (!m_issue && !m_out) begin
          p = rr_pick(req_valid, m_last, m_cool, m_owner);
          m_cool = -1;
          if (m_owner >= 0 && !req_lock[m_owner[1:0]]) m_owner = -1;
          if (p >= 0 && dp_ready) begin
            m_addr = req_addr[p[1:0]];
            m_dout = req_dout[p[1:0]];
            m_sreg = req_sreg[p[1:0]];
            m_attr = {req_write[p[1:0]], req_wide[p[1:0]],
                      req_io[p[1:0]], req_zero_seg[p[1:0]]};
            m_txlock = req_lock[p[1:0]];
            m_last = p;
            m_issue = 1;
          end
        end else if (m_issue) begin
          m_issue = 0;
          m_out = 1;
        end else if (dp_ready) begin
          m_out = 0;
          m_ack[m_last[1:0]] = 1'b1;
          m_din = dp_din;
          m_cool = m_last;
          if (req_lock[m_last[1:0]]) m_owner = m_last;
          else if (m_owner == m_last) m_owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("req_din", 32'(req_din), 32'(m_din));
      chk("dp_req", 32'(dp_req), 32'(m_issue));
      chk("busy", 32'(busy), 32'(m_issue | m_out));
      chk("grant_id", 32'(grant_id), 32'(m_last));
      chk("buslock", 32'(buslock_prefix),
          32'((m_owner >= 0) || ((m_issue || m_out) && m_txlock)));
      chk("dp_addr", 32'(dp_addr), 32'(m_addr));
      chk("dp_dout", 32'(dp_dout), 32'(m_dout));
      chk("dp_sreg", 32'(dp_sreg), 32'(m_sreg));
      chk("dp_attr", 32'({dp_write, dp_wide, dp_io, dp_zero_seg}),
          32'(m_attr));
    end
  end

  always @(negedge clk) begin : monitor
    if (dp_req === 1'b1) nreq++;
    for (int i = 0; i < N; i++)
      if (ack[i] === 1'b1) acks.push_back(i);
  end

  // Bus control unit: busy for bcu_lat cycles after each new dp_req.
  initial begin : bcu
    logic prev;
    prev = 0;
    forever begin
      @(negedge clk);
      if (dp_req && !prev) begin
        bcu_ready = 0;
        repeat (bcu_lat) @(negedge clk);
        dp_din = bcu_data;
        bcu_data = bcu_data + 16'h1111;
        bcu_ready = 1;
      end
      prev = dp_req;
    end
  end

  initial begin : ce_gen
    forever begin
      @(posedge clk);
      #1;
      if (ce_tog) ce_2 = ~ce_2;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_acks(input int n, input string nm);
    int t;
    t = 0;
    while (acks.size() < n && t < 300) begin
      @(negedge clk); #1; t++;
    end
    chk(nm, 32'(acks.size() >= n), 1);
  endtask

  task automatic wait_req(input string nm);
    int t;
    t = 0;
    while (dp_req !== 1'b1 && t < 300) begin
      @(negedge clk); #1; t++;
    end
    chk(nm, 32'(dp_req), 1);
  endtask

  task automatic do_reset;
    @(negedge clk); #1 reset = 1;
    @(negedge clk); #1 reset = 0;
  endtask

  function automatic int ack_at(input int i);
    return (i < acks.size()) ? acks[i] : -1;
  endfunction

  initial begin : main
    int n0, t;
    int ord2[6];
    int ord3[4];
    ord2 = '{0, 1, 2, 0, 1, 2};
    ord3 = '{1, 1, 1, 2};
    req_addr = '{16'h3000, 16'h2000, 16'h1000};
    req_dout = '{16'hC3C3, 16'hB2B2, 16'hA1A1};
    req_sreg = '{PS, DS1, DS0};
    repeat (2) @(negedge clk);
    #1 reset = 0;
    chk("rst_grant_id", 32'(grant_id), 2);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_buslock", 32'(buslock_prefix), 0);

    // Single read from requester 0
    bcu_data = 16'hBEEF;
    req_addr[0] = 16'h1234;
    req_sreg[0] = SS;
    req_wide[0] = 1;
    n0 = nreq;
    acks.delete();
    req_valid[0] = 1;
    wait_req("t1_req");
    chk("t1_addr", 32'(dp_addr), 32'h1234);
    chk("t1_sreg", 32'(dp_sreg), 32'(SS));
    chk("t1_wide", 32'(dp_wide), 1);
    chk("t1_write", 32'(dp_write), 0);
    wait_acks(1, "t1_ack_seen");
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_din", 32'(req_din), 32'hBEEF);
    req_valid[0] = 0;
    idle(1);
    chk("t1_ack_width", 32'(ack), 0);
    chk("t1_req_pulses", 32'(nreq - n0), 1);
    chk("t1_din_hold", 32'(req_din), 32'hBEEF);

    // Round robin with all three requesting
    do_reset();
    req_write = 3'b010;
    req_io = 3'b100;
    req_zero_seg = 3'b010;
    acks.delete();
    req_valid = 3'b111;
    wait_acks(6, "t2_six_acks");
    req_valid = '0;
    for (int i = 0; i < 6; i++) chk("t2_order", ack_at(i), ord2[i]);
    idle(3);

    // Locked sequence owned by requester 1
    acks.delete();
    req_lock[1] = 1;
    req_write[1] = 1;
    req_valid[1] = 1;
    wait_acks(1, "t3_first");
    chk("t3_lock1", 32'(buslock_prefix), 1);
    req_valid[0] = 1;
    req_valid[2] = 1;
    wait_acks(3, "t3_third");
    chk("t3_lock3", 32'(buslock_prefix), 1);
    req_lock[1] = 0;
    req_valid[1] = 0;
    wait_acks(4, "t3_fourth");
    req_valid = '0;
    chk("t3_unlock", 32'(buslock_prefix), 0);
    for (int i = 0; i < 4; i++) chk("t3_order", ack_at(i), ord3[i]);
    idle(2);

    // dp_ready low blocks grant
    hold_lo = 1;
    n0 = nreq;
    req_valid[0] = 1;
    idle(5);
    chk("t4_no_req", 32'(nreq - n0), 0);
    chk("t4_idle", 32'(busy), 0);
    hold_lo = 0;
    idle(1);
    chk("t4_issue", 32'(dp_req), 1);
    acks.delete();
    wait_acks(1, "t4_ack_seen");
    req_valid = '0;
    chk("t4_ack_id", ack_at(0), 0);
    idle(2);

    // Reset during WAIT
    bcu_lat = 6;
    acks.delete();
    req_valid[1] = 1;
    wait_req("t5_req");
    idle(2);
    chk("t5_wait", 32'(busy), 1);
    req_valid = '0;
    reset = 1;
    idle(1);
    chk("t5_ack", 32'(ack), 0);
    chk("t5_dp_req", 32'(dp_req), 0);
    chk("t5_din", 32'(req_din), 0);
    chk("t5_addr", 32'(dp_addr), 0);
    chk("t5_sreg", 32'(dp_sreg), 32'(DS0));
    chk("t5_grant", 32'(grant_id), 2);
    chk("t5_busy", 32'(busy), 0);
    reset = 0;
    idle(8);
    chk("t5_no_ack", 32'(acks.size()), 0);
    bcu_lat = 2;
    req_valid = 3'b011;
    wait_acks(1, "t5_next");
    req_valid = '0;
    chk("t5_next_id", ack_at(0), 0);
    idle(2);

    // ce_2-only stepping, valid dropped during WAIT
    ce_1 = 0;
    ce_tog = 1;
    acks.delete();
    req_valid[0] = 1;
    wait_req("t6_req");
    t = 0;
    while (!(busy && !dp_req) && t < 50) begin idle(1); t++; end
    chk("t6_in_wait", 32'(busy && !dp_req), 1);
    req_valid[0] = 0;
    wait_acks(1, "t6_ack_seen");
    chk("t6_ack_id", ack_at(0), 0);
    idle(4);
    ce_tog = 0;
    ce_1 = 1;
    ce_2 = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
